// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
// Used by fetch_stage and the stage registers.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc_adel;
    } if_id_t;

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: load on en, bubble insert keeps the PC.
// Also reused for the later stage registers.
import pipe_pkg::*;

module fd_reg #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{instr: NOP, pc: RESET_PC, valid: 1'b0, exc_adel: 1'b0};
        end else if (en) begin
            if (bubble)
                q <= '{instr: NOP, pc: d.pc, valid: 1'b0, exc_adel: 1'b0};
            else
                q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// F-stage: PC register, variable-latency imem fetch, F/D register.
// Define FETCH_ADDR_CHECK_EN to flag illegal fetch addresses.
import pipe_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter int          IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic [31:0] F_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] D_instr,
    output logic [31:0] D_PC,
    output logic        D_valid,
    output logic        D_exc_adel,
    output logic        fetch_busy
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  ibuf_q;
    logic         ibuf_exc_q;
    logic         addr_bad;
    logic         ack_eff;
    logic [31:0]  fetch_word;
    if_id_t       fd_d;
    if_id_t       fd_q;

`ifdef FETCH_ADDR_CHECK_EN
    localparam logic [32:0] IMEM_END =
        {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) << 2);

    assign addr_bad = (pc_q[1:0] != 2'b00)
                    || (pc_q < IMEM_BASE)
                    || ({1'b0, pc_q} >= IMEM_END);
`else
    assign addr_bad = 1'b0;
`endif

    assign imem_req   = (state == FETCH) && !addr_bad;
    assign imem_addr  = pc_q;
    assign F_PC       = pc_q;
    // An illegal address completes at once as a flagged nop
    assign ack_eff    = (state == FETCH) && (addr_bad || imem_ack);
    assign fetch_word = addr_bad ? NOP : imem_rdata;
    assign fetch_busy = (state == FETCH) && !ack_eff;

    always_comb begin
        fd_d = '{instr: fetch_word, pc: pc_q,
                 valid: 1'b1, exc_adel: addr_bad};
        if (state == HELD)
            fd_d = '{instr: ibuf_q, pc: pc_q,
                     valid: 1'b1, exc_adel: ibuf_exc_q};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            ibuf_q     <= NOP;
            ibuf_exc_q <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (ack_eff && stall) begin
                        ibuf_q     <= fetch_word;
                        ibuf_exc_q <= addr_bad;
                        state      <= HELD;
                    end else if (ack_eff) begin
                        pc_q <= npc;
                    end
                end
                HELD: begin
                    if (!stall) begin
                        pc_q  <= npc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    fd_reg #(.RESET_PC(RESET_PC)) u_fd_reg (
        .clk    (clk),
        .rst_n  (reset),
        .en     (!stall),
        .bubble ((state == FETCH) && !ack_eff),
        .d      (fd_d),
        .q      (fd_q)
    );

    assign D_instr    = fd_q.instr;
    assign D_PC       = fd_q.pc;
    assign D_valid    = fd_q.valid;
    assign D_exc_adel = fd_q.exc_adel;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors plus a
// per-cycle comparison against a spec-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam int          WORDS  = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        ack = 1'b1;
    logic        use_tgt = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] npc;
    logic [31:0] F_PC, imem_addr, imem_rdata, D_instr, D_PC;
    logic        imem_req, D_valid, D_exc_adel, fetch_busy;

    int checks = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic bit bad(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
        longint lo, hi;
        lo = longint'(BASE);
        hi = lo + 4 * WORDS;
        return (a % 4 != 0) || (longint'(a) < lo) || (longint'(a) >= hi);
`else
        return (a === 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    assign imem_rdata = mem(imem_addr);
    assign npc = use_tgt ? tgt : imem_addr + 32'd4;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .npc        (npc),
        .stall      (stall),
        .F_PC       (F_PC),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (ack),
        .imem_rdata (imem_rdata),
        .D_instr    (D_instr),
        .D_PC       (D_PC),
        .D_valid    (D_valid),
        .D_exc_adel (D_exc_adel),
        .fetch_busy (fetch_busy)
    );

    // Model: PC, "word waiting for stall to drop" and the F/D contents
    logic [31:0] m_pc = RST_PC, m_buf = 0, m_di = 0, m_dpc = RST_PC;
    bit          m_held = 0, m_bexc = 0, m_dv = 0, m_dexc = 0;

    always @(posedge clk or negedge reset) begin
        logic [31:0] nxt;
        logic [31:0] w;
        bit          got, b;
        if (!reset) begin
            m_pc = RST_PC; m_held = 0; m_buf = 0; m_bexc = 0;
            m_di = 0; m_dpc = RST_PC; m_dv = 0; m_dexc = 0;
        end else begin
            nxt = use_tgt ? tgt : m_pc + 32'd4;
            b   = bad(m_pc);
            got = b || ack;
            w   = b ? 32'h0 : mem(m_pc);
            if (m_held) begin
                if (!stall) begin
                    m_di = m_buf; m_dpc = m_pc; m_dv = 1; m_dexc = m_bexc;
                    m_pc = nxt; m_held = 0;
                end
            end else if (!stall) begin
                m_dpc = m_pc;
                m_di  = got ? w : 32'h0;
                m_dv  = got;
                m_dexc = got && b;
                if (got) m_pc = nxt;
            end else if (got) begin
                m_buf = w; m_bexc = b; m_held = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_F_PC", F_PC, m_pc);
            check("m_addr", imem_addr, m_pc);
            check("m_req", 32'(imem_req), 32'(!m_held && !bad(m_pc)));
            check("m_busy", 32'(fetch_busy), 32'(!m_held && !ack && !bad(m_pc)));
            check("m_D_instr", D_instr, m_di);
            check("m_D_PC", D_PC, m_dpc);
            check("m_D_valid", 32'(D_valid), 32'(m_dv));
            check("m_D_exc", 32'(D_exc_adel), 32'(m_dexc));
        end
    end

    task automatic cyc(input logic a, input logic s,
                       input logic ut, input logic [31:0] t);
        #1;
        ack = a; stall = s; use_tgt = ut; tgt = t;
        @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;
        #1;
        check("rst_addr", imem_addr, 32'h3000);
        check("rst_D_PC", D_PC, 32'h3000);
        check("rst_D_valid", 32'(D_valid), 32'd0);
        check("rst_D_instr", D_instr, 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);

        cyc(1, 0, 0, 0);
        check("seq_addr1", imem_addr, 32'h3004);
        check("seq_D_PC1", D_PC, 32'h3000);
        check("seq_valid1", 32'(D_valid), 32'd1);
        check("seq_instr1", D_instr, mem(32'h3000));

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("wait_F_PC", F_PC, 32'h3004);
        check("wait_valid", 32'(D_valid), 32'd0);
        check("wait_instr", D_instr, 32'd0);
        cyc(1, 0, 0, 0);
        check("wait_D_PC", D_PC, 32'h3004);
        check("wait_done", D_instr, mem(32'h3004));
        check("wait_F_PC2", F_PC, 32'h3008);

        cyc(1, 1, 0, 0);
        check("held_req", 32'(imem_req), 32'd0);
        check("held_D_PC", D_PC, 32'h3004);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("held_F_PC", F_PC, 32'h3008);
        cyc(0, 0, 0, 0);
        check("unheld_instr", D_instr, mem(32'h3008));
        check("unheld_D_PC", D_PC, 32'h3008);
        check("unheld_F_PC", F_PC, 32'h300C);

        cyc(1, 0, 1, 32'h3100);
        check("jmp_slot", D_PC, 32'h300C);
        check("jmp_addr", imem_addr, 32'h3100);
        cyc(1, 0, 0, 0);
        check("jmp_D_PC", D_PC, 32'h3100);
        check("jmp_next", imem_addr, 32'h3104);

        cyc(0, 1, 0, 0);
        check("stall_noack", F_PC, 32'h3104);
        cyc(1, 0, 1, 32'h3020);
        cyc(0, 0, 0, 0);
        check("pre_rst_pc", F_PC, 32'h3020);
        #2 reset = 1'b0;
        #1;
        check("async_F_PC", F_PC, 32'h3000);
        check("async_valid", 32'(D_valid), 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

`ifdef FETCH_ADDR_CHECK_EN
        cyc(1, 0, 1, 32'h3002);
        check("adel_req1", 32'(imem_req), 32'd0);
        cyc(0, 0, 1, 32'h0);
        check("adel_exc1", 32'(D_exc_adel), 32'd1);
        check("adel_pc1", D_PC, 32'h3002);
        check("adel_instr1", D_instr, 32'h0);
        check("adel_req2", 32'(imem_req), 32'd0);
        cyc(0, 1, 1, 32'h3000);
        cyc(0, 0, 1, 32'h3000);
        check("adel_exc2", 32'(D_exc_adel), 32'd1);
        check("adel_pc2", D_PC, 32'h0);
`endif

        for (int i = 0; i < 80; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 5) == 0),
                BASE + (32'($urandom_range(0, 255)) << 2));
        end

        #1 chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage of the 5-stage MIPS pipeline. Holds the architectural PC (F_PC) and fetches from instruction memory over a variable-latency req/ack interface.
- Drives the F/D pipeline register (D_instr, D_PC, D_valid).
- Consumes the next-PC value produced by the NPC block and feeds F_PC back to it.
- Honours the hazard unit's stall and inserts bubbles while memory is slow.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IMEM_BASE, 32'h0000_3000, lowest legal fetch address.
- IMEM_WORDS, 4096, number of 32-bit words in instruction memory.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- npc  input  32  next PC from the NPC block; sampled only when the PC advances.
- stall  input  1  hazard-unit stall; freezes F_PC and the F/D register.
- F_PC  output  32  current fetch PC, to NPC and to imem_addr.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; always equals F_PC.
- imem_ack  input  1  memory returns data this cycle; ignored unless imem_req=1.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- D_instr  output  32  F/D register: instruction.
- D_PC  output  32  F/D register: PC of D_instr.
- D_valid  output  1  F/D register holds a real instruction (0 = bubble).
- D_exc_adel  output  1  fetch address error flag for D_instr.
- fetch_busy  output  1  1 when in FETCH with no ack this cycle (informational, to hazard unit).

Behaviour:
- Reset (asynchronous, reset=0):
  - F_PC=RESET_PC, state=FETCH.
  - D_instr=0, D_PC=RESET_PC, D_valid=0, D_exc_adel=0, instruction buffer=0.
- States (2):
  - FETCH: imem_req=1.
  - HELD: imem_req=0; instruction already buffered, waiting for stall to drop.
- FETCH, imem_ack=1, stall=0:
  - D_instr<=imem_rdata, D_PC<=F_PC, D_valid<=1, F_PC<=npc.
  - Stay in FETCH.
- FETCH, imem_ack=1, stall=1:
  - ibuf<=imem_rdata, go to HELD.
  - F_PC and the F/D register unchanged.
- FETCH, imem_ack=0, stall=0:
  - Insert bubble: D_instr<=0, D_PC<=F_PC, D_valid<=0.
  - F_PC unchanged.
- FETCH, imem_ack=0, stall=1: all registers unchanged.
- HELD, stall=0:
  - D_instr<=ibuf, D_PC<=F_PC, D_valid<=1, F_PC<=npc.
  - Go to FETCH.
- HELD, stall=1: hold everything.
- Latency and throughput:
  - Zero-wait memory (ack in the same cycle as req): 1 instruction per cycle, 1-cycle F to D latency.
  - N wait cycles insert N bubbles.
- The PC advances only on the F to D transfer. npc is never sampled otherwise, so a branch or jump target computed in D is taken exactly once.
- fetch_busy = (state==FETCH) & ~imem_ack.
- F_PC arithmetic: 32-bit, no saturation. Wrap-around is the NPC block's concern.
- Reset mid-request: an outstanding request is abandoned. A late ack arriving after reset while in FETCH is accepted as the RESET_PC fetch. Memory must squash its own pending access on reset.

Optional Feature:
- Macro: FETCH_ADDR_CHECK_EN.
- Enabled: F_PC is illegal if F_PC[1:0]!=0, F_PC<IMEM_BASE, or F_PC>=IMEM_BASE+4*IMEM_WORDS. For an illegal F_PC:
  - imem_req=0.
  - The block behaves as if ack arrived with rdata=32'h0000_0000 (nop).
  - D_exc_adel<=1 alongside that transfer. Stall handling is identical, via HELD with the flag buffered.
- Disabled: no checking; D_exc_adel is constant 0. The port is always present.

Decomposition:
- Shared package `pipe_pkg`:
  - RESET_PC default.
  - NOP constant (32'h0).
  - Fetch-state enum (FETCH, HELD).
- One natural sub-module: `fd_reg`. It is the F/D pipeline register with enable (=~stall) and bubble insert, and is reused by later D/E stage registers.

Test Plan:
- Reset release, ack tied 1, stall=0, npc=F_PC+4 → imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; D_PC lags by 1; D_valid=1 from cycle 2.
- Ack delayed 2 cycles on 0x3004 → two bubbles (D_valid=0, D_instr=0); then D_instr=rdata, D_PC=0x3004; F_PC stays 0x3004 during the wait.
- Ack with stall=1 for 3 cycles → state HELD, imem_req=0, F/D unchanged; on stall drop, D_instr=buffered word and F_PC<=npc exactly once.
- npc=0x0000_3100 (jump target) while D_PC=0x3008 → next imem_addr=0x3100; intervening delay slot fetched normally.
- Reset asserted mid-wait with F_PC=0x3020 → F_PC=0x3000 and D_valid=0 immediately, asynchronously.
- FETCH_ADDR_CHECK_EN with npc=0x3002, and separately npc=0x0000_0000 → imem_req=0; D_instr=0, D_exc_adel=1, D_PC=bad address.
